// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch : instruction fetch stage feeding decode.
//
// Owns the program counter, issues one request at a time to a variable-latency
// instruction memory and presents each returned word together with its PC+2
// through a registered output slot. A one-entry skid buffer absorbs a response
// that arrives while decode is stalled. Redirects flush the slot and skid and
// restart fetch; a word whose top five bits are zero is a HALT and stops
// further requests until the next redirect or reset.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : an odd fetch address is never issued; Err is set (sticky) and
//               the stage halts.
//   undefined : bit 0 of every PC load is forced to 0 and Err is tied low.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   Stall        in   decode cannot accept the slot this cycle
//   Redirect     in   flush and refetch from RedirectPC (highest priority)
//   RedirectPC   in   16-bit redirect target
//   IMemReq      out  memory request outstanding
//   IMemAddr     out  memory request address
//   IMemReady    in   one-cycle response strobe
//   IMemData     in   returned instruction word
//   Instr        out  instruction to decode
//   PcPlus2      out  address of Instr plus 2 (mod 2^16)
//   InstrValid   out  Instr/PcPlus2 valid
//   Halted       out  fetch stopped after a HALT (or alignment error)
//   Err          out  sticky misaligned-fetch error
// -----------------------------------------------------------------------------
module fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  output logic        IMemReq,
  output logic [15:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [15:0] IMemData,
  output logic [15:0] Instr,
  output logic [15:0] PcPlus2,
  output logic        InstrValid,
  output logic        Halted,
  output logic        Err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [15:0] NOP_WORD = 16'h0800;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_pc;
  logic [15:0] r_drain_addr;
  logic [15:0] r_instr;
  logic [15:0] r_pcp2;
  logic        r_valid;
  logic [15:0] r_skid_data;
  logic [15:0] r_skid_pcp2;
  logic        r_skid_full;

  logic [15:0] w_redir_pc;
  logic [15:0] w_reset_pc;
  logic        w_redir_bad;
  logic        w_pc_bad;
  logic        w_err_set;
  logic        w_consume;
  logic        w_resp;
  logic        w_slot_take;
  logic        w_is_halt;
  logic [15:0] w_pc_inc;
  logic        w_in_flight;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_err;
  assign w_redir_pc  = RedirectPC;
  assign w_reset_pc  = RESET_PC;
  assign w_redir_bad = RedirectPC[0];
  assign w_pc_bad    = r_pc[0];
`else
  assign w_redir_pc  = RedirectPC & 16'hFFFE;
  assign w_reset_pc  = RESET_PC & 16'hFFFE;
  assign w_redir_bad = 1'b0;
  assign w_pc_bad    = 1'b0;
`endif

  assign w_consume   = r_valid & ~Stall;
  assign w_resp      = (r_state == S_WAIT) & IMemReady & ~Redirect;
  // A response lands in the slot whenever the slot is free by the end of this
  // cycle; in WAIT the skid is always empty, so no ordering hazard exists.
  assign w_slot_take = ~r_valid | w_consume;
  assign w_is_halt   = (IMemData[15:11] == 5'b00000);
  assign w_pc_inc    = r_pc + 16'd2;
  // A request still outstanding at redirect time must be drained before the
  // new address can be presented.
  assign w_in_flight = ((r_state == S_WAIT) | (r_state == S_DRAIN)) & ~IMemReady;

  assign IMemReq    = (r_state == S_WAIT) | (r_state == S_DRAIN);
  assign IMemAddr   = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  assign Instr      = r_instr;
  assign PcPlus2    = r_pcp2;
  assign InstrValid = r_valid;
  assign Halted     = (r_state == S_HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    if (Redirect) begin
      if (w_redir_bad) begin
        w_next    = S_HALTED;
        w_err_set = 1'b1;
      end else if (w_in_flight) begin
        w_next = S_DRAIN;
      end else begin
        w_next = S_WAIT;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pc_bad) begin
            w_next    = S_HALTED;
            w_err_set = 1'b1;
          end else if (!r_skid_full) begin
            w_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (IMemReady) begin
            if (w_is_halt)        w_next = S_HALTED;
            else if (w_slot_take) w_next = S_WAIT;
            else                  w_next = S_IDLE;
          end
        end
        S_DRAIN: begin
          if (IMemReady) w_next = S_WAIT;
        end
        default: w_next = S_HALTED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= w_reset_pc;
      r_drain_addr <= 16'h0000;
    end else if (Redirect) begin
      r_pc <= w_redir_pc;
      // Only the first redirect of a drain captures the in-flight address.
      if ((r_state == S_WAIT) && !IMemReady) r_drain_addr <= r_pc;
    end else if (w_resp) begin
      r_pc <= w_pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr     <= NOP_WORD;
      r_pcp2      <= 16'h0000;
      r_valid     <= 1'b0;
      r_skid_data <= NOP_WORD;
      r_skid_pcp2 <= 16'h0000;
      r_skid_full <= 1'b0;
    end else if (Redirect) begin
      r_valid     <= 1'b0;
      r_skid_full <= 1'b0;
    end else if (w_resp) begin
      if (w_slot_take) begin
        r_instr <= IMemData;
        r_pcp2  <= w_pc_inc;
        r_valid <= 1'b1;
      end else begin
        r_skid_data <= IMemData;
        r_skid_pcp2 <= w_pc_inc;
        r_skid_full <= 1'b1;
      end
    end else if (w_consume) begin
      if (r_skid_full) begin
        r_instr     <= r_skid_data;
        r_pcp2      <= r_skid_pcp2;
        r_skid_full <= 1'b0;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end
  assign Err = r_err;
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;

  logic        clk;
  logic        rst;
  logic        Stall;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic        IMemReq;
  logic [15:0] IMemAddr;
  logic        IMemReady;
  logic [15:0] IMemData;
  logic [15:0] Instr;
  logic [15:0] PcPlus2;
  logic        InstrValid;
  logic        Halted;
  logic        Err;

  int checks = 0;
  int errors = 0;

  fetch #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemReady  (IMemReady),
    .IMemData   (IMemData),
    .Instr      (Instr),
    .PcPlus2    (PcPlus2),
    .InstrValid (InstrValid),
    .Halted     (Halted),
    .Err        (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge and
  // inputs for the next edge are driven from the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic rdy, input logic [15:0] data);
    IMemReady = rdy;
    IMemData  = data;
  endtask

  initial begin
    rst = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 16'h0000;
    IMemReady = 1'b0; IMemData = 16'h0000;
    tick(); tick();

    // Reset values
    chk("rst_req",   {15'd0, IMemReq},    16'd0);
    chk("rst_addr",  IMemAddr,            16'h0000);
    chk("rst_instr", Instr,               16'h0800);
    chk("rst_pcp2",  PcPlus2,             16'h0000);
    chk("rst_vld",   {15'd0, InstrValid}, 16'd0);
    chk("rst_halt",  {15'd0, Halted},     16'd0);
    chk("rst_err",   {15'd0, Err},        16'd0);

    // Sequential fetch ending in HALT
    rst = 1'b1;
    tick();
    chk("seq_req0",  {15'd0, IMemReq}, 16'd1);
    chk("seq_addr0", IMemAddr,         16'h0000);
    mem(1'b1, 16'h4000);
    tick();
    chk("seq_i0",    Instr,               16'h4000);
    chk("seq_p0",    PcPlus2,             16'h0002);
    chk("seq_v0",    {15'd0, InstrValid}, 16'd1);
    chk("seq_addr1", IMemAddr,            16'h0002);
    chk("seq_req1",  {15'd0, IMemReq},    16'd1);
    mem(1'b1, 16'h4001);
    tick();
    chk("seq_i1",    Instr,    16'h4001);
    chk("seq_p1",    PcPlus2,  16'h0004);
    chk("seq_addr2", IMemAddr, 16'h0004);
    mem(1'b1, 16'h0000);
    tick();
    chk("seq_i2",    Instr,            16'h0000);
    chk("seq_p2",    PcPlus2,          16'h0006);
    chk("seq_halt",  {15'd0, Halted},  16'd1);
    chk("seq_noreq", {15'd0, IMemReq}, 16'd0);
    mem(1'b0, 16'h0000);
    tick();
    chk("seq_v3",    {15'd0, InstrValid}, 16'd0);
    chk("seq_noreq2",{15'd0, IMemReq},    16'd0);

    // Redirect out of HALTED, then stall with back-to-back responses
    Redirect = 1'b1; RedirectPC = 16'h0010;
    tick();
    Redirect = 1'b0;
    chk("hr_halt", {15'd0, Halted},  16'd0);
    chk("hr_req",  {15'd0, IMemReq}, 16'd1);
    chk("hr_addr", IMemAddr,         16'h0010);
    Stall = 1'b1;
    mem(1'b1, 16'h4100);
    tick();
    chk("st_i0",   Instr,    16'h4100);
    chk("st_p0",   PcPlus2,  16'h0012);
    chk("st_addr", IMemAddr, 16'h0012);
    mem(1'b1, 16'h4200);
    tick();
    mem(1'b0, 16'h0000);
    chk("st_req_drop", {15'd0, IMemReq}, 16'd0);
    chk("st_hold_i",   Instr,            16'h4100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_v",   {15'd0, InstrValid}, 16'd1);
      chk("st_hold_i",   Instr,               16'h4100);
      chk("st_hold_req", {15'd0, IMemReq},    16'd0);
    end
    Stall = 1'b0;
    tick();
    chk("st_i1",   Instr,               16'h4200);
    chk("st_p1",   PcPlus2,             16'h0014);
    chk("st_v1",   {15'd0, InstrValid}, 16'd1);
    chk("st_req1", {15'd0, IMemReq},    16'd0);
    tick();
    chk("st_v2",    {15'd0, InstrValid}, 16'd0);
    chk("st_req2",  {15'd0, IMemReq},    16'd1);
    chk("st_addr2", IMemAddr,            16'h0014);

    // Redirect while a request is in flight -> drain
    Redirect = 1'b1; RedirectPC = 16'h0100;
    tick();
    Redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("dr_req",  {15'd0, IMemReq},    16'd1);
      chk("dr_addr", IMemAddr,            16'h0014);
      chk("dr_v",    {15'd0, InstrValid}, 16'd0);
      if (i < 2) tick();
    end
    mem(1'b1, 16'h4300);
    tick();
    chk("dr_disc_v", {15'd0, InstrValid}, 16'd0);
    chk("dr_newaddr", IMemAddr,           16'h0100);
    chk("dr_newreq", {15'd0, IMemReq},    16'd1);
    mem(1'b1, 16'h4400);
    tick();
    chk("dr_i",    Instr,    16'h4400);
    chk("dr_p",    PcPlus2,  16'h0102);
    chk("dr_addr2",IMemAddr, 16'h0102);

    // Redirect coinciding with a response
    Redirect = 1'b1; RedirectPC = 16'h0200;
    mem(1'b1, 16'h4500);
    tick();
    Redirect = 1'b0;
    mem(1'b0, 16'h0000);
    chk("rr_v",    {15'd0, InstrValid}, 16'd0);
    chk("rr_addr", IMemAddr,            16'h0200);
    chk("rr_req",  {15'd0, IMemReq},    16'd1);

    // PC wrap at 16'hFFFE
    Redirect = 1'b1; RedirectPC = 16'hFFFE;
    mem(1'b1, 16'h4550);
    tick();
    Redirect = 1'b0;
    chk("wr_addr0", IMemAddr, 16'hFFFE);
    mem(1'b1, 16'h4600);
    tick();
    chk("wr_i",     Instr,               16'h4600);
    chk("wr_p",     PcPlus2,             16'h0000);
    chk("wr_v",     {15'd0, InstrValid}, 16'd1);
    chk("wr_addr1", IMemAddr,            16'h0000);

    // HALT, then redirect to an odd address
    mem(1'b1, 16'h0000);
    tick();
    mem(1'b0, 16'h0000);
    chk("h2_halt", {15'd0, Halted},  16'd1);
    chk("h2_req",  {15'd0, IMemReq}, 16'd0);
    chk("h2_p",    PcPlus2,          16'h0002);
    Redirect = 1'b1; RedirectPC = 16'h0101;
    tick();
    Redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("al_halt", {15'd0, Halted},  16'd1);
    chk("al_req",  {15'd0, IMemReq}, 16'd0);
    chk("al_err",  {15'd0, Err},     16'd1);
`else
    chk("al_halt", {15'd0, Halted},  16'd0);
    chk("al_req",  {15'd0, IMemReq}, 16'd1);
    chk("al_addr", IMemAddr,         16'h0100);
    chk("al_err",  {15'd0, Err},     16'd0);
`endif

    // Asynchronous reset mid-request
    #2;
    rst = 1'b0;
    #1;
    chk("ar_req",  {15'd0, IMemReq},    16'd0);
    chk("ar_addr", IMemAddr,            16'h0000);
    chk("ar_v",    {15'd0, InstrValid}, 16'd0);
    chk("ar_i",    Instr,               16'h0800);
    chk("ar_halt", {15'd0, Halted},     16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage, directly upstream of the decode stage. Owns the program counter, issues requests to a variable-latency instruction memory, and hands each instruction plus its PC+2 to decode through a registered output slot backed by a one-entry skid buffer. It honours decode stalls, PC redirects from branch/jump resolution, and stops fetching after a HALT.

## Interface
- `RESET_PC`, 16'h0000, PC value after reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset; asserted when 0.
- `Stall`  in  1  decode cannot accept this cycle; holds `Instr`/`InstrValid`.
- `Redirect`  in  1  flush and refetch from `RedirectPC`; priority over all other inputs.
- `RedirectPC`  in  16  new fetch address.
- `IMemReq`  out  1  request outstanding; address is `IMemAddr`.
- `IMemAddr`  out  16  request address; stable while `IMemReq`=1.
- `IMemReady`  in  1  one-cycle pulse; `IMemData` is valid in that cycle.
- `IMemData`  in  16  returned instruction word.
- `Instr`  out  16  instruction to decode.
- `PcPlus2`  out  16  address of `Instr` + 2, modulo 2^16.
- `InstrValid`  out  1  `Instr`/`PcPlus2` valid; consumed when `InstrValid & ~Stall`.
- `Halted`  out  1  fetch stopped after delivering a HALT.
- `Err`  out  1  sticky misaligned-fetch error (see Configuration).

## Operation
- Registers: `PC` (next/outstanding address), output slot {Instr, PcPlus2, InstrValid}, skid {data, pcplus2, full}, FSM state.
- States: IDLE, WAIT, DRAIN, HALTED. `IMemReq` = (state is WAIT or DRAIN). `IMemAddr` = `PC`.
- IDLE: go to WAIT when skid empty and not Redirect-blocked; otherwise stay.
- WAIT, `IMemReady`=0: stay. Request and address held until `IMemReady`.
- WAIT, `IMemReady`=1: word delivered into output slot if slot empty or being consumed this cycle, else into skid. `PC` ← `PC`+2 (16-bit wrap, 16'hFFFE → 16'h0000). Next state: HALTED if `IMemData[15:11]`=5'b00000; else WAIT if skid will be empty; else IDLE.
- Skid drains into the output slot on the first cycle the slot is consumed; skid then becomes empty.
- Redirect (any state): `InstrValid` ← 0, skid ← empty, `PC` ← `RedirectPC`, `Halted` ← 0. Next state DRAIN if in WAIT with `IMemReady`=0 (request still in flight); otherwise WAIT. Returning data in a Redirect cycle is discarded.
- DRAIN: keep `IMemReq`=1 with the old address captured at redirect time; on `IMemReady` discard data and go to WAIT at `PC`. A second Redirect in DRAIN only updates `PC`.
- HALTED: `IMemReq`=0, `Halted`=1; the HALT word remains deliverable through slot/skid normally. Left only by Redirect or reset.
- Reset values: `PC`=`RESET_PC`, state IDLE, `IMemReq`=0, `Instr`=16'h0800 (NOP), `PcPlus2`=0, `InstrValid`=0, skid empty, `Halted`=0, `Err`=0. Reset mid-request abandons the request; the memory must tolerate the dropped `IMemReq`.

## Timing
- First request: cycle 1 after reset release (IDLE→WAIT), `IMemReq` high in cycle 2.
- `IMemReady` in cycle N → `InstrValid`=1 in N+1; next request already asserted in N+1 (back-to-back throughput one instruction per memory response).
- Redirect in cycle N → `InstrValid`=0 from N+1; new address on `IMemAddr` from N+1 (or after drain completes).
- `Halted` rises in cycle after the HALT word's `IMemReady`.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: a request address with bit 0 = 1 (from `RESET_PC` or `RedirectPC`) is not issued; `Err` ← 1 (sticky until reset), state → HALTED, `Halted`=1.
- Undefined: bit 0 of `PC` forced to 0 on every load; `Err` tied 0.

## Test plan
- Reset release, memory ready 1 cycle after each request, words 16'h4000,16'h4001,16'h0000 → `IMemAddr` 0,2,4; `Instr` delivered in order with `PcPlus2` 2,4,6; `Halted`=1 after third; `IMemReq` stays 0.
- `Stall` held 5 cycles with back-to-back responses → slot holds first word, skid holds second, `IMemReq` drops; release → both delivered in order, fetch resumes at next address.
- Redirect to 16'h0100 while request to 16'h0006 in flight (ready 3 cycles later) → DRAIN, returned word discarded, next request to 16'h0100, no stale `InstrValid`.
- Redirect and `IMemReady` same cycle → data dropped, `IMemAddr`=16'h0100 next cycle; Redirect in HALTED → `Halted`=0, fetch resumes.
- `PC`=16'hFFFE fetch → `PcPlus2`=16'h0000, next `IMemAddr`=16'h0000.
- With `FETCH_ALIGN_CHECK_EN`: Redirect to 16'h0101 → no request issued, `Err`=1, `Halted`=1; without macro, request to 16'h0100.
